// File: rtl/hamming_secded_decoder.sv
// Purpose: pipelined extended-Hamming (SECDED) decoder. It corrects single-bit errors and flags double-bit errors.
// Latency: 2 cycles from the input handshake to out_valid. Throughput is 1 word/cycle.
// Backpressure: one shared advance enable (!out_valid || out_ready) stalls both stages, and in_ready follows it.
//
// Optional feature macro: HAMMING_DEC_COUNTERS_EN
//   defined   -> corr_cnt / uncorr_cnt are saturating counters of delivered words
//   undefined -> counters are not built, they read 0, and cnt_clr is ignored
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   in_valid/in_ready/in_word    N-bit received codeword (N = 2^R)
//   out_valid/out_ready          output handshake
//   out_data                     K corrected data bits (K = N-R-1)
//   out_status                   00 clean, 01 corrected, 10 overall-parity-bit error, 11 double error
//   out_err_loc                  position of the flipped bit for status 01, else 0
//   cnt_clr, corr_cnt, uncorr_cnt  error counters and their clear
module hamming_secded_decoder #(
  parameter int R     = 4,
  parameter int CNT_W = 16,
  localparam int N    = 2**R,
  localparam int K    = N - R - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_data,
  output logic [1:0]       out_status,
  output logic [R-1:0]     out_err_loc,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  // Codeword position of data bit k. Data bits skip position 0 and every power of two.
  function automatic int data_pos(input int k);
    int cnt;
    data_pos = 0;
    cnt      = 0;
    for (int p = 3; p < N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) data_pos = p;
        cnt++;
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // Syndrome and overall parity of the incoming word
  // ---------------------------------------------------------------------------
  logic [R-1:0] in_syn;
  logic         in_par;

  always_comb begin
    in_syn = '0;
    for (int p = 1; p < N; p++) begin
      if (in_word[p]) in_syn = in_syn ^ R'(p);
    end
  end

  assign in_par = ^in_word;

  // ---------------------------------------------------------------------------
  // Stage 1: raw word, syndrome and parity
  // ---------------------------------------------------------------------------
  logic         s1_valid;
  logic [N-1:0] s1_word;
  logic [R-1:0] s1_syn;
  logic         s1_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_word <= in_word;
        s1_syn  <= in_syn;
        s1_par  <= in_par;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Classification and correction of the stage-1 word
  // ---------------------------------------------------------------------------
  logic         syn_nz;
  logic [1:0]   s1_status;
  logic         fix;
  logic [N-1:0] flip_mask;
  logic [N-1:0] corr_word;
  logic [K-1:0] s1_data;
  logic [R-1:0] s1_err_loc;

  assign syn_nz = |s1_syn;

  always_comb begin
    s1_status = 2'b00;
    if (!syn_nz && s1_par)      s1_status = 2'b10; // only the overall parity bit flipped
    else if (syn_nz && s1_par)  s1_status = 2'b01; // single error at position syn
    else if (syn_nz && !s1_par) s1_status = 2'b11; // even number of flips, uncorrectable
  end

  assign fix        = (s1_status == 2'b01);
  assign flip_mask  = fix ? ({{(N-1){1'b0}}, 1'b1} << s1_syn) : '0;
  assign corr_word  = s1_word ^ flip_mask;
  assign s1_err_loc = fix ? s1_syn : '0;

  for (genvar k = 0; k < K; k++) begin : g_extract
    assign s1_data[k] = corr_word[data_pos(k)];
  end

  // Parity positions carry no data. This only gathers them so that they are consumed.
  logic [R:0] nondata_bits;
  logic       unused_nondata;
  assign nondata_bits[0] = corr_word[0];
  for (genvar r = 0; r < R; r++) begin : g_nondata
    assign nondata_bits[r+1] = corr_word[2**r];
  end
  assign unused_nondata = ^nondata_bits;

  // ---------------------------------------------------------------------------
  // Stage 2: registered outputs. They only change on adv, so they stay stable while stalled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_status  <= 2'b00;
      out_err_loc <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= s1_data;
        out_status  <= s1_status;
        out_err_loc <= s1_err_loc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error counters
  // ---------------------------------------------------------------------------
`ifdef HAMMING_DEC_COUNTERS_EN
  logic out_hs;
  assign out_hs = out_valid && out_ready;

  // A clear in the same cycle as an increment wins.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_hs) begin
      if ((out_status == 2'b01 || out_status == 2'b10) && corr_cnt != {CNT_W{1'b1}})
        corr_cnt <= corr_cnt + 1'b1;
      if (out_status == 2'b11 && uncorr_cnt != {CNT_W{1'b1}})
        uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule
